// File: rtl/lcd_bus_pkg.sv
// Shared types for the LCD bus controller: command opcodes, FSM states and a sizing helper.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        OP_WR_REG  = 3'd0,
        OP_WR_DATA = 3'd1,
        OP_RD_DATA = 3'd2,
        OP_STREAM  = 3'd3,
        OP_HW_RST  = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STRB_LO,
        STRB_HI,
        S_WAIT,
        HWRST
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; last is high on the final cycle of the phase.
module lcd_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// 8080-style parallel LCD bus master: register/data writes, single reads, streamed
// pixel bursts under one chip-select, and a timed panel hardware reset.
module lcd_bus_ctrl #(
    parameter int DW    = 16,
    parameter int CNT_W = 19,
    parameter int T_SU  = 1,
    parameter int T_LO  = 2,
    parameter int T_HI  = 2,
    parameter int T_RST = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DW-1:0]    cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             done,
    output logic             lcd_cs_n,
    output logic             lcd_wr_n,
    output logic             lcd_rd_n,
    output logic             lcd_rs,
    output logic             lcd_rst_n,
    output logic [DW-1:0]    lcd_db_o,
    output logic             lcd_db_oe,
    input  logic [DW-1:0]    lcd_db_i
);

    import lcd_bus_pkg::*;

    localparam int T_MAX = max_of(max_of(T_SU, T_LO), max_of(T_HI, T_RST));
    localparam int TW    = $clog2(T_MAX + 1);

    state_t             state, state_nxt;
    op_t                op_q;
    logic [CNT_W-1:0]   rem;
    logic               rdy_en;
    logic               accept;
    logic               s_hs;
    logic               done_nxt;
    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_last;

    lcd_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    // rdy_en keeps cmd_ready low while reset is held and for the release cycle
    assign cmd_ready = rdy_en && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign s_ready   = (state == S_WAIT);
    assign s_hs      = s_valid && s_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rdy_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WR_REG, OP_WR_DATA, OP_RD_DATA: begin
                            state_nxt = SETUP;
                            tmr_load  = 1'b1;
                            tmr_val   = TW'(T_SU - 1);
                        end
                        OP_STREAM: begin
                            if (cmd_cnt != '0) begin
                                state_nxt = SETUP;
                                tmr_load  = 1'b1;
                                tmr_val   = TW'(T_SU - 1);
                            end else begin
                                done_nxt = 1'b1;
                            end
                        end
                        OP_HW_RST: begin
                            state_nxt = HWRST;
                            tmr_load  = 1'b1;
                            tmr_val   = TW'(T_RST - 1);
                        end
                        default: done_nxt = 1'b1;
                    endcase
                end
            end
            SETUP: begin
                if (tmr_last) begin
                    if (op_q == OP_STREAM) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = STRB_LO;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(T_LO - 1);
                    end
                end
            end
            S_WAIT: begin
                if (s_hs) begin
                    state_nxt = STRB_LO;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(T_LO - 1);
                end
            end
            STRB_LO: begin
                if (tmr_last) begin
                    state_nxt = STRB_HI;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(T_HI - 1);
                end
            end
            STRB_HI: begin
                if (tmr_last) begin
                    if (op_q == OP_STREAM && rem != '0) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            HWRST: begin
                if (tmr_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rem counts words still to be handshaken, so it is already decremented in STRB_HI
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_WR_REG;
            lcd_rs   <= 1'b0;
            lcd_db_o <= '0;
            rem      <= '0;
        end else begin
            if (accept) begin
                op_q <= op_t'(cmd_op);
                case (cmd_op)
                    OP_WR_REG: begin
                        lcd_rs   <= 1'b0;
                        lcd_db_o <= cmd_data;
                    end
                    OP_WR_DATA: begin
                        lcd_rs   <= 1'b1;
                        lcd_db_o <= cmd_data;
                    end
                    OP_RD_DATA: lcd_rs <= 1'b1;
                    OP_STREAM: begin
                        lcd_rs <= 1'b1;
                        rem    <= cmd_cnt;
                    end
                    default: ;
                endcase
            end
            if (s_hs) begin
                lcd_db_o <= s_data;
                if (rem != '0) begin
                    rem <= rem - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (state == STRB_LO && tmr_last && op_q == OP_RD_DATA) begin
                rd_valid <= 1'b1;
                rd_data  <= lcd_db_i;
            end
        end
    end

    always_comb begin
        lcd_cs_n  = !(state inside {SETUP, STRB_LO, STRB_HI, S_WAIT});
        lcd_wr_n  = !(state == STRB_LO && op_q != OP_RD_DATA);
        lcd_rd_n  = !(state == STRB_LO && op_q == OP_RD_DATA);
        lcd_rst_n = (state != HWRST);
        lcd_db_oe = !(state != IDLE && op_q == OP_RD_DATA);
    end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Self-checking bench for lcd_bus_ctrl: table vectors, randomized ops against a timing
// model derived from the bus phase lengths, and hand-written reset sequences.
module tb_lcd_bus_ctrl;

    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int TSU  = 1;
    localparam int TLO  = 2;
    localparam int THI  = 2;
    localparam int TRST = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [CW-1:0] cmd_cnt;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic          lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_rst_n, lcd_db_oe;
    logic [DW-1:0] lcd_db_o, lcd_db_i;

    int    tests = 0;
    int    fails = 0;
    string tag   = "";

    lcd_bus_ctrl #(
        .DW(DW), .CNT_W(CW), .T_SU(TSU), .T_LO(TLO), .T_HI(THI), .T_RST(TRST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done),
        .lcd_cs_n(lcd_cs_n), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
        .lcd_rs(lcd_rs), .lcd_rst_n(lcd_rst_n),
        .lcd_db_o(lcd_db_o), .lcd_db_oe(lcd_db_oe), .lcd_db_i(lcd_db_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        int          cnt;
        logic [15:0] dbi;
        int          gap_word;
        int          gap_len;
        bit          rnd;
        int          exp_pulses;
        logic        exp_rs;
        int          exp_rstlow;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Cycles from acceptance to the done pulse, from the phase lengths alone
    function automatic int exp_done(input logic [2:0] op, input int cnt, input int stalls);
        case (op)
            3'd0, 3'd1, 3'd2: return TSU + TLO + THI;
            3'd3:             return (cnt == 0) ? 0 : TSU + cnt * (1 + TLO + THI) + stalls;
            3'd4:             return TRST;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [10:0] ctl_vec();
        return {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rst_n, lcd_rs, lcd_db_oe,
                cmd_ready, s_ready, rd_valid, done, busy};
    endfunction

    task automatic run_op(input vec_t v);
        logic [15:0] sent_q[$];
        logic [15:0] got_q[$];
        logic [15:0] cur = '0;
        logic [15:0] rdv_data = '0;
        logic        prev_wr = 1'b1;
        bit          is_bus = (v.op <= 3'd3);
        bit          is_rd  = (v.op == 3'd2);
        bit          gap;
        int done_idx = -1, done_cnt = 0, cs_low = 0, wr_low = 0, wr_first = -1;
        int rd_low = 0, rdv_cnt = 0, rdv_idx = -1, busy_cyc = 0, rst_low = 0;
        int rs_bad = 0, oe_bad = 0, db_bad = 0, rdy_bad = 0, srdy_bad = 0;
        int stalls = 0, sent = 0, gap_left = v.gap_len, exp_d;

        @(negedge clk);
        lcd_db_i  = v.dbi;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_cnt   = CW'(v.cnt);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!lcd_cs_n) cs_low++;
            if (!lcd_wr_n) begin
                wr_low++;
                if (wr_first < 0) wr_first = i;
                if (prev_wr) begin
                    got_q.push_back(lcd_db_o);
                    cur = lcd_db_o;
                end
                if (lcd_db_o !== cur) db_bad++;
            end
            prev_wr = lcd_wr_n;
            if (v.op <= 3'd1 && !lcd_cs_n && lcd_db_o !== v.data) db_bad++;
            if (!lcd_rd_n) rd_low++;
            if (rd_valid) begin
                rdv_cnt++;
                rdv_idx  = i;
                rdv_data = rd_data;
            end
            if (busy) busy_cyc++;
            if (busy && cmd_ready) rdy_bad++;
            if (s_ready && (lcd_cs_n || !lcd_wr_n || !busy)) srdy_bad++;
            if (!lcd_rst_n) rst_low++;
            if (!lcd_cs_n && lcd_rs !== v.exp_rs) rs_bad++;
            if (lcd_db_oe !== ((is_rd && i < TSU + TLO + THI) ? 1'b0 : 1'b1)) oe_bad++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (done_idx >= 0 && i >= done_idx + 2) break;
            gap = (sent == v.gap_word) && (gap_left > 0);
            if (s_ready && sent < v.cnt) begin
                if (gap || (v.rnd && $urandom_range(3) == 0)) begin
                    s_valid = 1'b0;
                    stalls++;
                    if (gap) gap_left--;
                end else begin
                    s_valid = 1'b1;
                    s_data  = 16'($urandom);
                    sent_q.push_back(s_data);
                    sent++;
                end
            end else begin
                s_valid = 1'($urandom_range(1));
                s_data  = 16'($urandom);
            end
        end
        s_valid = 1'b0;
        if (done_idx < 0) begin
            tests++;
            fails++;
            $display("FAIL %s/timeout: got no done expected done within 400 cycles", tag);
            return;
        end
        exp_d = exp_done(v.op, v.cnt, stalls);
        chk("done_idx", done_idx, exp_d);
        chk("done_once", done_cnt, 1);
        chk("busy_cycles", busy_cyc, exp_d);
        chk("cs_low", cs_low, is_bus ? exp_d : 0);
        chk("wr_low", wr_low, is_rd ? 0 : TLO * v.exp_pulses);
        chk("rd_low", rd_low, is_rd ? TLO : 0);
        chk("pulses", got_q.size(), is_rd ? 0 : v.exp_pulses);
        if (v.op <= 3'd1) chk("wr_first", wr_first, TSU);
        for (int k = 0; k < got_q.size(); k++) begin
            if (v.op <= 3'd1) chk("wr_data", got_q[k], v.data);
            else if (k < sent_q.size()) chk("stream_data", got_q[k], sent_q[k]);
        end
        chk("rd_valid_cnt", rdv_cnt, is_rd ? 1 : 0);
        if (is_rd) begin
            chk("rd_valid_idx", rdv_idx, TSU + TLO);
            chk("rd_data", rdv_data, v.dbi);
        end
        chk("lcd_rst_low", rst_low, v.exp_rstlow);
        chk("rs_stable", rs_bad, 0);
        chk("db_oe", oe_bad, 0);
        chk("db_stable", db_bad, 0);
        chk("ready_busy", rdy_bad, 0);
        chk("s_ready_scope", srdy_bad, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int          pulses;
        logic        prev_w;
        int          cs_seen, wr_seen;
        vec_t        rv;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_cnt = '0;
        s_valid = 1'b0; s_data = '0; lcd_db_i = '0;

        vecs[0] = '{3'd0, 16'h0022, 0,  16'h0000, -1, 0, 1'b0, 1,  1'b0, 0};
        vecs[1] = '{3'd2, 16'h0000, 0,  16'hBEEF, -1, 0, 1'b0, 1,  1'b1, 0};
        vecs[2] = '{3'd3, 16'h0000, 4,  16'h0000,  2, 3, 1'b0, 4,  1'b1, 0};
        vecs[3] = '{3'd3, 16'h0000, 0,  16'h0000, -1, 0, 1'b0, 0,  1'b1, 0};
        vecs[4] = '{3'd4, 16'h0000, 0,  16'h0000, -1, 0, 1'b0, 0,  1'b0, TRST};
        vecs[5] = '{3'd5, 16'h1234, 3,  16'h0000, -1, 0, 1'b0, 0,  1'b0, 0};
        vecs[6] = '{3'd1, 16'hA5C3, 0,  16'h0000, -1, 0, 1'b0, 1,  1'b1, 0};
        vecs[7] = '{3'd3, 16'h0000, 15, 16'h0000, -1, 0, 1'b0, 15, 1'b1, 0};
        vecs[8] = '{3'd7, 16'hFFFF, 0,  16'h0000, -1, 0, 1'b0, 0,  1'b0, 0};

        tag = "reset";
        repeat (3) @(negedge clk);
        chk("ctl", ctl_vec(), 11'b11110100000);
        chk("db_o", lcd_db_o, 0);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_pre_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("cmd_ready_post_edge", cmd_ready, 1);

        for (int n = 0; n < 9; n++) begin
            tag = $sformatf("vec%0d_op%0d", n, vecs[n].op);
            run_op(vecs[n]);
        end

        for (int n = 0; n < 20; n++) begin
            rv.op       = 3'($urandom_range(7));
            rv.data     = 16'($urandom);
            rv.cnt      = $urandom_range(6);
            rv.dbi      = 16'($urandom);
            rv.gap_word = -1;
            rv.gap_len  = 0;
            rv.rnd      = 1'b1;
            rv.exp_pulses = (rv.op <= 3'd2) ? 1 : (rv.op == 3'd3) ? rv.cnt : 0;
            rv.exp_rs     = (rv.op != 3'd0);
            rv.exp_rstlow = (rv.op == 3'd4) ? TRST : 0;
            tag = $sformatf("rnd%0d_op%0d", n, rv.op);
            run_op(rv);
        end

        tag = "rst_mid";
        @(negedge clk);
        cmd_op = 3'd3; cmd_cnt = CW'(10); cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        s_valid   = 1'b1;
        pulses    = 0;
        prev_w    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!lcd_wr_n && prev_w) pulses++;
            prev_w = lcd_wr_n;
            s_data = 16'($urandom) | 16'h0001;
            if (pulses == 2) break;
        end
        chk("reach_word2", pulses, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ctl", ctl_vec(), 11'b11110100000);
        chk("db_o", lcd_db_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_pre_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("cmd_ready_post_edge", cmd_ready, 1);
        chk("busy_post_edge", busy, 0);
        cs_seen = 0;
        wr_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (!lcd_cs_n) cs_seen++;
            if (!lcd_wr_n) wr_seen++;
        end
        chk("no_resume_cs", cs_seen, 0);
        chk("no_resume_wr", wr_seen, 0);
        s_valid = 1'b0;

        tag = "after_rst";
        run_op(vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 SHALL have parameter DW, 16, bus data width (8, 9, 16 or 18).
REQ-002 SHALL have parameter CNT_W, 19, stream word-count width.
REQ-003 SHALL have parameter T_SU, 1, cs_n-low-to-strobe setup cycles (>=1).
REQ-004 SHALL have parameter T_LO, 2, wr_n/rd_n low cycles (>=1).
REQ-005 SHALL have parameter T_HI, 2, wr_n/rd_n high cycles after strobe (>=1).
REQ-006 SHALL have parameter T_RST, 1000, lcd_rst_n low cycles for the hardware-reset op.
REQ-007 SHALL have ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset.
REQ-008 SHALL have ports: cmd_valid input 1; cmd_ready output 1; cmd_op input 3 (lcd_bus_pkg::op_t); cmd_data input DW; cmd_cnt input CNT_W.
REQ-009 SHALL have ports: s_valid input 1; s_ready output 1; s_data input DW (stream pixel words).
REQ-010 SHALL have ports: rd_valid output 1; rd_data output DW (read-back word).
REQ-011 SHALL have ports: busy output 1; done output 1 (one-cycle completion pulse).
REQ-012 SHALL have ports: lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_rst_n outputs 1; lcd_db_o output DW; lcd_db_oe output 1; lcd_db_i input DW.

Function
REQ-013 SHALL accept a command on a cycle with cmd_valid && cmd_ready; cmd_ready = 1 only in IDLE.
REQ-014 SHALL implement ops: WR_REG (rs=0), WR_DATA (rs=1), RD_DATA (rs=1), STREAM (rs=1, cmd_cnt words from s_*), HW_RST.
REQ-015 SHALL use states IDLE, SETUP, STRB_LO, STRB_HI, S_WAIT, HWRST; in IDLE cs_n=wr_n=rd_n=1 and busy=0.
REQ-016 SHALL, for WR_REG/WR_DATA, hold IDLE->SETUP for T_SU cycles (cs_n=0, db driven), then STRB_LO for T_LO cycles (wr_n=0), then STRB_HI for T_HI cycles (wr_n=1, cs_n=0), then return to IDLE.
REQ-017 SHALL hold lcd_db_o and lcd_rs stable from SETUP entry until STRB_HI exit.
REQ-018 SHALL, for RD_DATA, drive lcd_db_oe=0 from acceptance onward, pulse rd_n in place of wr_n, register lcd_db_i on the last STRB_LO cycle, and assert rd_valid with rd_data for exactly one cycle on the first STRB_HI cycle.
REQ-019 SHALL, for STREAM with cmd_cnt>0, go SETUP -> S_WAIT; in S_WAIT s_ready=1 and cs_n=0; on s_valid handshake, latch s_data into lcd_db_o and run STRB_LO/STRB_HI; afterwards return to S_WAIT while words remain, else go to IDLE.
REQ-020 SHALL keep cs_n low for the whole STREAM burst, including S_WAIT stalls of any length.
REQ-021 SHALL complete STREAM with cmd_cnt=0 with no bus activity: done pulses the cycle after acceptance.
REQ-022 SHALL treat cmd_cnt=2^CNT_W-1 as the maximum; the remaining-word counter SHALL NOT wrap.
REQ-023 SHALL, for HW_RST, drive lcd_rst_n=0 for T_RST cycles with cs_n=1, then return to IDLE.
REQ-024 SHALL pulse done for one cycle on the first IDLE cycle after any op completes; busy = (state != IDLE).
REQ-025 SHALL assert s_ready only in S_WAIT; s_data SHALL be ignored otherwise.
REQ-026 SHALL treat undefined cmd_op as a no-op: accepted, done pulsed the next cycle, no bus activity.
REQ-027 SHALL make lcd_db_oe=1 in every state except during RD_DATA.

Reset
REQ-028 SHALL on rst_n=0, at any time including mid-burst, asynchronously force IDLE with cs_n=wr_n=rd_n=1, lcd_rst_n=1, lcd_rs=0, lcd_db_o=0, lcd_db_oe=1, cmd_ready=0, s_ready=0, rd_valid=0, done=0, busy=0, and counters=0.
REQ-029 SHALL assert cmd_ready on the first clk edge after rst_n deasserts; an interrupted burst SHALL NOT resume.

Structure
REQ-030 SHALL place op_t, state_t and the op encodings in package lcd_bus_pkg.
REQ-031 SHALL use one sub-module, lcd_phase_timer: a loadable down-counter sized for max(T_SU,T_LO,T_HI,T_RST) that produces a last-cycle flag.

Verification (DW=16, T_SU=1, T_LO=2, T_HI=2, T_RST=8)
REQ-032 SHALL check WR_REG with data 0x0022: cs_n low 5 cycles, wr_n low on cycles 2-3, rs=0, db=0x0022 throughout, done 1 cycle after.
REQ-033 SHALL check RD_DATA with lcd_db_i=0xBEEF: oe=0, rd_n low 2 cycles, rd_valid 1 cycle with rd_data=0xBEEF.
REQ-034 SHALL check STREAM cnt=4 with s_valid gapped on word 3 for 3 cycles: exactly 4 wr_n pulses with the correct data, cs_n continuously low, one done.
REQ-035 SHALL check STREAM cnt=0: no cs_n activity, done the cycle after acceptance.
REQ-036 SHALL check that rst_n asserted during the 2nd word of STREAM cnt=10 immediately forces the REQ-028 values, with cmd_ready=1 one edge after release.
REQ-037 SHALL check HW_RST: lcd_rst_n low exactly 8 cycles, busy high throughout, then done.
